bbq_ctrl_multi: RTL and testbench

//  Parametrised successor of the single-queue BBQ control unit. Accepts buffer-address

---
 rtl/bbq_ctrl_multi.sv | 167 ++++++++++++++++
 tb/tb_bbq_ctrl_multi.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bbq_ctrl_multi.sv
// bbq_ctrl_multi: multi-priority BBQ control unit.
// Descriptors {prio, buff_addr} are queued in NUM_PRIO per-priority FIFO buckets
// and drained lowest-priority-index first into a small output FIFO with
// valid/ready backpressure on both sides.
// Optional feature macro: BBQ_CTRL_STATS_EN adds enqueue/dequeue counters and an
// occupancy high-water mark.
module bbq_ctrl_multi #(
  parameter int HEAP_ENTRY_DWIDTH = 32,
  parameter int NUM_PRIO          = 8,
  parameter int BUCKET_DEPTH      = 4,
  parameter int OUT_BUFF_SIZE     = 4,
  localparam int PRIO_AWIDTH      = $clog2(NUM_PRIO),
  localparam int OCC_W            = $clog2(NUM_PRIO*BUCKET_DEPTH+OUT_BUFF_SIZE+1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [PRIO_AWIDTH-1:0]       in_prio,
  input  logic [HEAP_ENTRY_DWIDTH-1:0] in_buff_addr,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PRIO_AWIDTH-1:0]       out_prio,
  output logic [HEAP_ENTRY_DWIDTH-1:0] out_buff_addr,
  output logic [OCC_W-1:0]             occupancy
`ifdef BBQ_CTRL_STATS_EN
  ,
  output logic [31:0]                  stat_enq_cnt,
  output logic [31:0]                  stat_deq_cnt,
  output logic [OCC_W-1:0]             stat_occ_max
`endif
);

  localparam int BW  = $clog2(BUCKET_DEPTH);
  localparam int CW  = BW + 1;
  localparam int OW  = $clog2(OUT_BUFF_SIZE);
  localparam int OCW = OW + 1;
  localparam int EW  = PRIO_AWIDTH + HEAP_ENTRY_DWIDTH;

  // Bucket storage and bookkeeping
  logic [HEAP_ENTRY_DWIDTH-1:0] bucket_mem [NUM_PRIO][BUCKET_DEPTH];
  logic [BW-1:0]                head_reg   [NUM_PRIO];
  logic [BW-1:0]                tail_reg   [NUM_PRIO];
  logic [CW-1:0]                cnt_reg    [NUM_PRIO];
  logic [NUM_PRIO-1:0]          bitmap;
  logic [NUM_PRIO-1:0]          enq_hit;
  logic [NUM_PRIO-1:0]          pop_hit;

  // Output FIFO
  logic [EW-1:0]                out_mem [OUT_BUFF_SIZE];
  logic [OW-1:0]                out_wr_ptr_reg;
  logic [OW-1:0]                out_rd_ptr_reg;
  logic [OCW-1:0]               out_cnt_reg;

  logic                         in_fire;
  logic                         out_pop;
  logic                         pop_en;
  logic [PRIO_AWIDTH-1:0]       pop_idx;
  logic [HEAP_ENTRY_DWIDTH-1:0] pop_data;
  logic [OCC_W-1:0]             occupancy_reg;
  logic [OCC_W-1:0]             occupancy_next;

  // Full check uses registered counts only, so a full bucket never accepts even
  // if it is being popped in the same cycle.
  assign in_ready  = (cnt_reg[in_prio] != CW'(BUCKET_DEPTH));
  assign in_fire   = in_valid && in_ready;
  assign out_valid = (out_cnt_reg != '0);
  assign out_pop   = out_valid && out_ready;
  // A slot is free if the FIFO is not full or its head leaves this cycle.
  assign pop_en    = (|bitmap) && ((out_cnt_reg != OCW'(OUT_BUFF_SIZE)) || out_pop);
  assign pop_data  = bucket_mem[pop_idx][head_reg[pop_idx]];
  assign {out_prio, out_buff_addr} = out_mem[out_rd_ptr_reg];
  assign occupancy = occupancy_reg;

  for (genvar gi = 0; gi < NUM_PRIO; gi++) begin : g_bucket
    assign bitmap[gi]  = (cnt_reg[gi] != '0);
    assign enq_hit[gi] = in_fire && (in_prio == PRIO_AWIDTH'(gi));
    assign pop_hit[gi] = pop_en && (pop_idx == PRIO_AWIDTH'(gi));
  end

  // Find-first-set: lowest non-empty bucket index wins
  always_comb begin
    pop_idx = '0;
    for (int i = NUM_PRIO - 1; i >= 0; i--) begin
      if (bitmap[i]) pop_idx = PRIO_AWIDTH'(i);
    end
  end

  // Bucket pointers and counts; enqueue and pop on one bucket cancel in the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        head_reg[i] <= '0;
        tail_reg[i] <= '0;
        cnt_reg[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_PRIO; i++) begin
        if (enq_hit[i]) tail_reg[i] <= tail_reg[i] + BW'(1);
        if (pop_hit[i]) head_reg[i] <= head_reg[i] + BW'(1);
        if (enq_hit[i] && !pop_hit[i])      cnt_reg[i] <= cnt_reg[i] + CW'(1);
        else if (!enq_hit[i] && pop_hit[i]) cnt_reg[i] <= cnt_reg[i] - CW'(1);
      end
    end
  end

  // Bucket data array write (contents survive reset on purpose)
  always_ff @(posedge clk) begin
    if (in_fire) bucket_mem[in_prio][tail_reg[in_prio]] <= in_buff_addr;
  end

  // Output FIFO data array write with the popped bucket head
  always_ff @(posedge clk) begin
    if (pop_en) out_mem[out_wr_ptr_reg] <= {pop_idx, pop_data};
  end

  // Output FIFO pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_wr_ptr_reg <= '0;
      out_rd_ptr_reg <= '0;
      out_cnt_reg    <= '0;
    end else begin
      if (pop_en)  out_wr_ptr_reg <= out_wr_ptr_reg + OW'(1);
      if (out_pop) out_rd_ptr_reg <= out_rd_ptr_reg + OW'(1);
      if (pop_en && !out_pop)      out_cnt_reg <= out_cnt_reg + OCW'(1);
      else if (!pop_en && out_pop) out_cnt_reg <= out_cnt_reg - OCW'(1);
    end
  end

  // Total occupancy: bucket-to-FIFO transfer does not change it
  always_comb begin
    occupancy_next = occupancy_reg;
    if (in_fire && !out_pop)      occupancy_next = occupancy_reg + OCC_W'(1);
    else if (!in_fire && out_pop) occupancy_next = occupancy_reg - OCC_W'(1);
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) occupancy_reg <= '0;
    else      occupancy_reg <= occupancy_next;
  end

`ifdef BBQ_CTRL_STATS_EN
  logic [31:0]      stat_enq_reg;
  logic [31:0]      stat_deq_reg;
  logic [OCC_W-1:0] stat_max_reg;

  assign stat_enq_cnt = stat_enq_reg;
  assign stat_deq_cnt = stat_deq_reg;
  assign stat_occ_max = stat_max_reg;

  // Free-running wrap-around counters and occupancy high-water mark
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_enq_reg <= '0;
      stat_deq_reg <= '0;
      stat_max_reg <= '0;
    end else begin
      if (in_fire) stat_enq_reg <= stat_enq_reg + 32'd1;
      if (out_pop) stat_deq_reg <= stat_deq_reg + 32'd1;
      if (occupancy_next > stat_max_reg) stat_max_reg <= occupancy_next;
    end
  end
`endif

endmodule

// File: tb/tb_bbq_ctrl_multi.sv
// Testbench for bbq_ctrl_multi: directed scenarios plus randomized traffic
// checked against a queue-based model of the bucket/output-FIFO rules.
module tb_bbq_ctrl_multi;

  localparam int HW = 32;
  localparam int NUM_PRIO = 8;
  localparam int BUCKET_DEPTH = 4;
  localparam int OUT_BUFF_SIZE = 4;
  localparam int PW = 3;
  localparam int OCC_W = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] in_prio = '0;
  logic [HW-1:0] in_buff_addr = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [PW-1:0] out_prio;
  logic [HW-1:0] out_buff_addr;
  logic [OCC_W-1:0] occupancy;
`ifdef BBQ_CTRL_STATS_EN
  logic [31:0]      stat_enq_cnt;
  logic [31:0]      stat_deq_cnt;
  logic [OCC_W-1:0] stat_occ_max;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  bbq_ctrl_multi #(
    .HEAP_ENTRY_DWIDTH(HW), .NUM_PRIO(NUM_PRIO),
    .BUCKET_DEPTH(BUCKET_DEPTH), .OUT_BUFF_SIZE(OUT_BUFF_SIZE)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_prio(in_prio),
    .in_buff_addr(in_buff_addr),
    .out_valid(out_valid), .out_ready(out_ready), .out_prio(out_prio),
    .out_buff_addr(out_buff_addr), .occupancy(occupancy)
`ifdef BBQ_CTRL_STATS_EN
    , .stat_enq_cnt(stat_enq_cnt), .stat_deq_cnt(stat_deq_cnt),
    .stat_occ_max(stat_occ_max)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          p;
    logic [31:0] a;
  } ent_t;

  ent_t bk[$];   // all bucketed entries in arrival order
  ent_t oq[$];   // output FIFO
  int m_enq = 0;
  int m_deq = 0;
  int m_peak = 0;

  function automatic int bcount(int p);
    int n = 0;
    foreach (bk[i]) if (bk[i].p == p) n++;
    return n;
  endfunction

  function automatic int m_occ();
    return bk.size() + oq.size();
  endfunction

  task automatic model_clear();
    bk.delete();
    oq.delete();
    m_enq = 0;
    m_deq = 0;
    m_peak = 0;
  endtask

  // Advance one clock: decisions from pre-edge state, applied at the edge.
  task automatic tick();
    bit acc, deq, mv;
    int midx, mp;
    ent_t e;
    acc = in_valid && (bcount(int'(in_prio)) < BUCKET_DEPTH);
    e.p = int'(in_prio);
    e.a = in_buff_addr;
    deq = out_ready && (oq.size() > 0);
    midx = 0;
    mp = NUM_PRIO;
    foreach (bk[i]) if (bk[i].p < mp) begin mp = bk[i].p; midx = i; end
    mv = (bk.size() > 0) && ((oq.size() < OUT_BUFF_SIZE) || deq);
    @(posedge clk);
    if (deq) begin
      $display("deq prio=%0d addr=%08h", oq[0].p, oq[0].a);
      oq.delete(0);
      m_deq++;
    end
    if (mv) begin
      oq.push_back(bk[midx]);
      bk.delete(midx);
    end
    if (acc) begin
      bk.push_back(e);
      m_enq++;
    end
    if (m_occ() > m_peak) m_peak = m_occ();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== '0) begin bad++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    tick();
    total++; if (out_valid !== 1'b0 || occupancy !== '0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL post_reset got v=%b occ=%0d rdy=%b exp v=0 occ=0 rdy=1", out_valid, occupancy, in_ready);
    end
  endtask

  task automatic test_latency();
    in_valid = 1'b1; in_prio = 3'd3; in_buff_addr = 32'hA5; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (occupancy !== 6'd1) begin bad++; $display("FAIL lat_occ got=%0d exp=1", occupancy); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL lat_early_valid got=%b exp=0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_prio !== 3'd3 || out_buff_addr !== 32'hA5) begin
      bad++; $display("FAIL lat_out got v=%b p=%0d a=%h exp v=1 p=3 a=a5", out_valid, out_prio, out_buff_addr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || occupancy !== '0) begin
      bad++; $display("FAIL lat_drain got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
    end
  endtask

  task automatic test_priority();
    logic [31:0] exp_a [6];
    int          exp_p [6];
    int k;
    exp_a = '{32'hF0, 32'hF1, 32'h10, 32'h20, 32'h30, 32'h11};
    exp_p = '{7, 7, 5, 1, 0, 5};
    do_reset();
    // two fillers occupy half the output FIFO
    in_valid = 1'b1; in_prio = 3'd7; in_buff_addr = 32'hF0; tick();
    in_buff_addr = 32'hF1; tick();
    in_valid = 1'b0; tick(); tick();
    in_valid = 1'b1;
    in_prio = 3'd5; in_buff_addr = 32'h10; tick();
    in_prio = 3'd1; in_buff_addr = 32'h20; tick();
    in_prio = 3'd5; in_buff_addr = 32'h11; tick();
    in_prio = 3'd0; in_buff_addr = 32'h30; tick();
    in_valid = 1'b0;
    tick();
    total++; if (occupancy !== 6'd6) begin bad++; $display("FAIL prio_occ got=%0d exp=6", occupancy); end
    out_ready = 1'b1;
    k = 0;
    for (int c = 0; c < 40 && k < 6; c++) begin
      if (out_valid) begin
        total++; if (out_buff_addr !== exp_a[k] || int'(out_prio) != exp_p[k]) begin
          bad++; $display("FAIL prio_order[%0d] got p=%0d a=%h exp p=%0d a=%h", k, out_prio, out_buff_addr, exp_p[k], exp_a[k]);
        end
        k++;
      end
      tick();
    end
    out_ready = 1'b0;
    total++; if (k != 6) begin bad++; $display("FAIL prio_count got=%0d exp=6", k); end
  endtask

  task automatic test_bucket_full();
    int seen;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1; in_prio = 3'd7;
    for (int i = 0; i < 4; i++) begin in_buff_addr = 32'h70 + i; tick(); end
    in_prio = 3'd2;
    for (int i = 0; i < 4; i++) begin in_buff_addr = 32'h20 + i; tick(); end
    in_valid = 1'b0;
    tick(); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_rdy_p2 got=%b exp=0", in_ready); end
    in_prio = 3'd6; #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL full_rdy_p6 got=%b exp=1", in_ready); end
    in_prio = 3'd2; in_buff_addr = 32'h2F; in_valid = 1'b1;
    tick(); tick(); tick();
    total++; if (occupancy !== 6'(m_occ()) || m_occ() != 8) begin
      bad++; $display("FAIL full_hold_occ got=%0d exp=8", occupancy);
    end
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 60 && (in_valid || m_occ() > 0); c++) begin
      if (out_valid) begin
        total++; if (oq.size() == 0 || out_buff_addr !== oq[0].a || int'(out_prio) != oq[0].p) begin
          bad++; $display("FAIL full_drain got p=%0d a=%h exp model head", out_prio, out_buff_addr);
        end
        if (out_buff_addr === 32'h2F) seen++;
      end
      if (in_valid && in_ready) begin tick(); in_valid = 1'b0; end
      else tick();
    end
    out_ready = 1'b0;
    in_valid = 1'b0;
    total++; if (seen != 1) begin bad++; $display("FAIL full_fifth_delivered got=%0d exp=1", seen); end
  endtask

  task automatic test_backpressure();
    int sent, hs;
    bit offering, acc_m, prev_stall;
    logic [PW-1:0] prev_p;
    logic [HW-1:0] prev_a;
    sent = 0; hs = 0; offering = 0; prev_stall = 0;
    prev_p = '0; prev_a = '0;
    do_reset();
    for (int c = 0; c < 20000 && !(sent == 1000 && m_occ() == 0); c++) begin
      if (!offering && sent < 1000 && $urandom_range(0, 9) < 7) begin
        offering = 1;
        in_valid = 1'b1;
        in_prio = PW'($urandom_range(0, NUM_PRIO - 1));
        in_buff_addr = {16'($urandom), 16'(sent)};
      end
      out_ready = 1'($urandom_range(0, 1));
      #1;
      acc_m = offering && (bcount(int'(in_prio)) < BUCKET_DEPTH);
      total++; if (in_ready !== (bcount(int'(in_prio)) < BUCKET_DEPTH)) begin
        bad++; $display("FAIL bp_in_ready cyc=%0d got=%b", c, in_ready);
      end
      total++; if (out_valid !== (oq.size() > 0)) begin
        bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=%b", c, out_valid, oq.size() > 0);
      end
      total++; if (occupancy !== 6'(m_occ())) begin
        bad++; $display("FAIL bp_occ cyc=%0d got=%0d exp=%0d", c, occupancy, m_occ());
      end
      if (out_valid && oq.size() > 0) begin
        total++; if (out_buff_addr !== oq[0].a || int'(out_prio) != oq[0].p) begin
          bad++; $display("FAIL bp_head cyc=%0d got p=%0d a=%h exp p=%0d a=%h", c, out_prio, out_buff_addr, oq[0].p, oq[0].a);
        end
      end
      if (prev_stall) begin
        total++; if (out_buff_addr !== prev_a || out_prio !== prev_p) begin
          bad++; $display("FAIL bp_stable cyc=%0d got p=%0d a=%h exp p=%0d a=%h", c, out_prio, out_buff_addr, prev_p, prev_a);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_p = out_prio;
      prev_a = out_buff_addr;
      if (out_valid && out_ready) hs++;
      tick();
      if (acc_m) begin sent++; offering = 0; in_valid = 1'b0; end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    total++; if (hs != 1000 || sent != 1000) begin
      bad++; $display("FAIL bp_delivered got=%0d sent=%0d exp=1000", hs, sent);
    end
  endtask

  task automatic test_reset_midtraffic();
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_prio = PW'($urandom_range(0, NUM_PRIO - 1));
      in_buff_addr = 32'hC0 + i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    total++; if (occupancy !== 6'd5) begin bad++; $display("FAIL mid_pre_occ got=%0d exp=5", occupancy); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_out_valid got=%b exp=0", out_valid); end
    total++; if (occupancy !== '0) begin bad++; $display("FAIL mid_occ got=%0d exp=0", occupancy); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b exp=1", in_ready); end
    model_clear();
    @(negedge clk);
    rst = 1'b1;
    tick(); tick();
    total++; if (out_valid !== 1'b0 || occupancy !== '0) begin
      bad++; $display("FAIL mid_after got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy);
    end
  endtask

`ifdef BBQ_CTRL_STATS_EN
  task automatic test_stats();
    int hs;
    do_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_prio = PW'(i % NUM_PRIO);
      in_buff_addr = 32'h100 + i;
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    hs = 0;
    for (int c = 0; c < 100 && hs < 7; c++) begin
      out_ready = 1'b1;
      #1;
      if (out_valid) hs++;
      tick();
    end
    out_ready = 1'b0;
    total++; if (stat_enq_cnt !== 32'd10) begin bad++; $display("FAIL stat_enq got=%0d exp=10", stat_enq_cnt); end
    total++; if (stat_deq_cnt !== 32'd7) begin bad++; $display("FAIL stat_deq got=%0d exp=7", stat_deq_cnt); end
    total++; if (stat_occ_max !== 6'(m_peak) || m_peak != 10) begin
      bad++; $display("FAIL stat_occ_max got=%0d exp=%0d", stat_occ_max, m_peak);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_latency();
    test_priority();
    test_bucket_full();
    test_backpressure();
    test_reset_midtraffic();
`ifdef BBQ_CTRL_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
